// File: rtl/cn_lut_bank_sched.sv
// cn_lut_bank_sched
// Bank-conflict scheduler for the four-port check-node LUT. A batch of four
// (page, bank) lookups is latched, issued to two dual-port banks at most two
// per bank per cycle, and the four results are returned together.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | ready for a batch; req_ready=1
// ISSUE | granting pending lookups, up to two per bank per cycle
// WAIT  | all lookups issued; waiting for the last read data to return
// RESP  | result batch presented on rsp_A..D until rsp_ready
module cn_lut_bank_sched #(
    parameter int PAGE_W  = 5,
    parameter int DATA_W  = 3,
    parameter int RD_LAT  = 1,
    parameter int STALL_W = 16   // width of the saturating stall counter (1..16)
) (
    input  logic              sys_clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [PAGE_W-1:0] page_addr_A,
    input  logic [PAGE_W-1:0] page_addr_B,
    input  logic [PAGE_W-1:0] page_addr_C,
    input  logic [PAGE_W-1:0] page_addr_D,
    input  logic              bank_addr_A,
    input  logic              bank_addr_B,
    input  logic              bank_addr_C,
    input  logic              bank_addr_D,
    output logic              b0_en_0,
    output logic              b0_en_1,
    output logic              b1_en_0,
    output logic              b1_en_1,
    output logic [PAGE_W-1:0] b0_addr_0,
    output logic [PAGE_W-1:0] b0_addr_1,
    output logic [PAGE_W-1:0] b1_addr_0,
    output logic [PAGE_W-1:0] b1_addr_1,
    input  logic [DATA_W-1:0] b0_dout_0,
    input  logic [DATA_W-1:0] b0_dout_1,
    input  logic [DATA_W-1:0] b1_dout_0,
    input  logic [DATA_W-1:0] b1_dout_1,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_A,
    output logic [DATA_W-1:0] rsp_B,
    output logic [DATA_W-1:0] rsp_C,
    output logic [DATA_W-1:0] rsp_D,
    output logic [15:0]       stall_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    // latched batch; requester index 0..3 = A..D
    logic [PAGE_W-1:0]   r_page [4];
    logic [3:0]          r_bank;
    logic [3:0]          r_pend;
    logic [STALL_W-1:0]  r_stall;

    // tag delay line: per requester, valid plus the {bank, port} it was issued on
    logic [3:0]          r_tag_vld  [RD_LAT];
    logic [3:0]          r_tag_bank [RD_LAT];
    logic [3:0]          r_tag_port [RD_LAT];

    logic [DATA_W-1:0]   r_rsp [4];

    logic [3:0]          w_grant;
    logic [3:0]          w_gport;
    logic [1:0]          w_take;
    logic                w_en   [2][2];
    logic [PAGE_W-1:0]   w_addr [2][2];
    logic [DATA_W-1:0]   w_dout [2][2];
    logic [2:0]          w_n1;
    logic                w_conflict;
    logic                w_accept;
    logic                w_pipe_busy;

    assign w_dout[0][0] = b0_dout_0;
    assign w_dout[0][1] = b0_dout_1;
    assign w_dout[1][0] = b1_dout_0;
    assign w_dout[1][1] = b1_dout_1;

    assign w_accept   = (r_state == IDLE) && req_valid;

    // a batch needs two issue cycles unless the banks split exactly 2/2
    assign w_n1       = 3'(bank_addr_A) + 3'(bank_addr_B) + 3'(bank_addr_C) + 3'(bank_addr_D);
    assign w_conflict = (w_n1 != 3'd2);

    // per-bank grant: two lowest-indexed pending requesters, first to port 0
    always_comb begin
        w_grant = '0;
        w_gport = '0;
        w_take  = '0;
        for (int b = 0; b < 2; b++) begin
            w_en[b][0]   = 1'b0;
            w_en[b][1]   = 1'b0;
            w_addr[b][0] = '0;
            w_addr[b][1] = '0;
        end
        if (r_state == ISSUE) begin
            for (int b = 0; b < 2; b++) begin
                w_take = '0;
                for (int i = 0; i < 4; i++) begin
                    if (r_pend[i] && (r_bank[i] == 1'(b))) begin
                        if (!w_take[0]) begin
                            w_grant[i]   = 1'b1;
                            w_gport[i]   = 1'b0;
                            w_en[b][0]   = 1'b1;
                            w_addr[b][0] = r_page[i];
                            w_take[0]    = 1'b1;
                        end else if (!w_take[1]) begin
                            w_grant[i]   = 1'b1;
                            w_gport[i]   = 1'b1;
                            w_en[b][1]   = 1'b1;
                            w_addr[b][1] = r_page[i];
                            w_take[1]    = 1'b1;
                        end
                    end
                end
            end
        end
    end

    // tags still in flight beyond the one emerging this cycle
    always_comb begin
        w_pipe_busy = 1'b0;
        for (int s = 0; s < RD_LAT - 1; s++) begin
            if (|r_tag_vld[s]) begin
                w_pipe_busy = 1'b1;
            end
        end
    end

    // state register
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (req_valid) w_state_nxt = ISSUE;
            ISSUE:   if ((r_pend & ~w_grant) == 4'b0000) w_state_nxt = WAIT;
            WAIT:    if (!w_pipe_busy) w_state_nxt = RESP;
            RESP:    if (rsp_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // batch latch, pending mask and saturating stall counter
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                r_page[i] <= '0;
            end
            r_bank  <= '0;
            r_pend  <= '0;
            r_stall <= '0;
        end else if (w_accept) begin
            r_page[0] <= page_addr_A;
            r_page[1] <= page_addr_B;
            r_page[2] <= page_addr_C;
            r_page[3] <= page_addr_D;
            r_bank    <= {bank_addr_D, bank_addr_C, bank_addr_B, bank_addr_A};
            r_pend    <= 4'b1111;
            if (w_conflict && (r_stall != {STALL_W{1'b1}})) begin
                r_stall <= r_stall + 1'b1;
            end
        end else if (r_state == ISSUE) begin
            r_pend <= r_pend & ~w_grant;
        end
    end

    // tag delay line matching the bank read latency
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < RD_LAT; s++) begin
                r_tag_vld[s]  <= '0;
                r_tag_bank[s] <= '0;
                r_tag_port[s] <= '0;
            end
        end else begin
            r_tag_vld[0]  <= w_grant;
            r_tag_bank[0] <= r_bank;
            r_tag_port[0] <= w_gport;
            for (int s = 1; s < RD_LAT; s++) begin
                r_tag_vld[s]  <= r_tag_vld[s-1];
                r_tag_bank[s] <= r_tag_bank[s-1];
                r_tag_port[s] <= r_tag_port[s-1];
            end
        end
    end

    // capture read data into the requester slot named by the emerging tag
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                r_rsp[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (r_tag_vld[RD_LAT-1][i]) begin
                    r_rsp[i] <= w_dout[r_tag_bank[RD_LAT-1][i]][r_tag_port[RD_LAT-1][i]];
                end
            end
        end
    end

    assign req_ready = (r_state == IDLE);
    assign rsp_valid = (r_state == RESP);

    assign b0_en_0   = w_en[0][0];
    assign b0_en_1   = w_en[0][1];
    assign b1_en_0   = w_en[1][0];
    assign b1_en_1   = w_en[1][1];
    assign b0_addr_0 = w_addr[0][0];
    assign b0_addr_1 = w_addr[0][1];
    assign b1_addr_0 = w_addr[1][0];
    assign b1_addr_1 = w_addr[1][1];

    assign rsp_A     = r_rsp[0];
    assign rsp_B     = r_rsp[1];
    assign rsp_C     = r_rsp[2];
    assign rsp_D     = r_rsp[3];

    assign stall_cnt = 16'(r_stall);

endmodule

// File: tb/tb_cn_lut_bank_sched.sv
// Directed bench for cn_lut_bank_sched with a behavioural 1-cycle bank model.
module tb_cn_lut_bank_sched;

    localparam int PAGE_W  = 5;
    localparam int DATA_W  = 3;
    localparam int STALL_W = 8;
    localparam logic [15:0] STALL_MAX = 16'd255;

    logic              sys_clk = 1'b0;
    logic              rst;
    logic              req_valid, req_ready;
    logic [PAGE_W-1:0] page_addr_A, page_addr_B, page_addr_C, page_addr_D;
    logic              bank_addr_A, bank_addr_B, bank_addr_C, bank_addr_D;
    logic              b0_en_0, b0_en_1, b1_en_0, b1_en_1;
    logic [PAGE_W-1:0] b0_addr_0, b0_addr_1, b1_addr_0, b1_addr_1;
    logic [DATA_W-1:0] b0_dout_0 = '0, b0_dout_1 = '0, b1_dout_0 = '0, b1_dout_1 = '0;
    logic              rsp_valid, rsp_ready;
    logic [DATA_W-1:0] rsp_A, rsp_B, rsp_C, rsp_D;
    logic [15:0]       stall_cnt;

    int checks = 0;
    int errors = 0;

    logic [3:0]  w_en;
    logic [19:0] w_addr;
    logic [11:0] w_rsp;
    assign w_en   = {b0_en_0, b0_en_1, b1_en_0, b1_en_1};
    assign w_addr = {b0_addr_0, b0_addr_1, b1_addr_0, b1_addr_1};
    assign w_rsp  = {rsp_A, rsp_B, rsp_C, rsp_D};

    cn_lut_bank_sched #(
        .PAGE_W (PAGE_W),
        .DATA_W (DATA_W),
        .RD_LAT (1),
        .STALL_W(STALL_W)
    ) dut (
        .sys_clk    (sys_clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .page_addr_A(page_addr_A),
        .page_addr_B(page_addr_B),
        .page_addr_C(page_addr_C),
        .page_addr_D(page_addr_D),
        .bank_addr_A(bank_addr_A),
        .bank_addr_B(bank_addr_B),
        .bank_addr_C(bank_addr_C),
        .bank_addr_D(bank_addr_D),
        .b0_en_0    (b0_en_0),
        .b0_en_1    (b0_en_1),
        .b1_en_0    (b1_en_0),
        .b1_en_1    (b1_en_1),
        .b0_addr_0  (b0_addr_0),
        .b0_addr_1  (b0_addr_1),
        .b1_addr_0  (b1_addr_0),
        .b1_addr_1  (b1_addr_1),
        .b0_dout_0  (b0_dout_0),
        .b0_dout_1  (b0_dout_1),
        .b1_dout_0  (b1_dout_0),
        .b1_dout_1  (b1_dout_1),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_A      (rsp_A),
        .rsp_B      (rsp_B),
        .rsp_C      (rsp_C),
        .rsp_D      (rsp_D),
        .stall_cnt  (stall_cnt)
    );

    always #5 sys_clk = ~sys_clk;

    // LUT contents: low page bits XOR {page[4], page[3], bank}
    function automatic logic [2:0] lut(input logic b, input logic [4:0] p);
        return p[2:0] ^ {p[4], p[3], b};
    endfunction

    // bank memories, read latency 1
    always @(posedge sys_clk) begin
        if (b0_en_0) b0_dout_0 <= lut(1'b0, b0_addr_0);
        if (b0_en_1) b0_dout_1 <= lut(1'b0, b0_addr_1);
        if (b1_en_0) b1_dout_0 <= lut(1'b1, b1_addr_0);
        if (b1_en_1) b1_dout_1 <= lut(1'b1, b1_addr_1);
    end

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    // present a batch in the current (IDLE) cycle; returns in cycle 1
    task automatic send(input logic [4:0] pa, input logic [4:0] pb, input logic [4:0] pc,
                        input logic [4:0] pd, input logic [3:0] bk);
        page_addr_A = pa; page_addr_B = pb; page_addr_C = pc; page_addr_D = pd;
        bank_addr_A = bk[0]; bank_addr_B = bk[1]; bank_addr_C = bk[2]; bank_addr_D = bk[3];
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
    endtask

    task automatic handshake();
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %0b exp 1", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %0b exp 0", rsp_valid); end
        checks++; if (w_en !== 4'b0) begin errors++; $display("FAIL reset_en got %h exp 0", w_en); end
        checks++; if (w_addr !== 20'b0) begin errors++; $display("FAIL reset_addr got %h exp 0", w_addr); end
        checks++; if (w_rsp !== 12'b0) begin errors++; $display("FAIL reset_rsp got %h exp 0", w_rsp); end
        checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL reset_stall got %0d exp 0", stall_cnt); end
    endtask

    task automatic test_no_conflict();
        logic [11:0] exp_rsp;
        exp_rsp = {lut(1'b0, 5'd3), lut(1'b1, 5'd7), lut(1'b0, 5'd12), lut(1'b1, 5'd31)};
        send(5'd3, 5'd7, 5'd12, 5'd31, 4'b1010);
        checks++; if (w_en !== 4'b1111) begin errors++; $display("FAIL nc_c1_en got %h exp f", w_en); end
        checks++; if (w_addr !== {5'd3, 5'd12, 5'd7, 5'd31}) begin errors++; $display("FAIL nc_c1_addr got %h exp %h", w_addr, {5'd3, 5'd12, 5'd7, 5'd31}); end
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL nc_c1_req_ready got %0b exp 0", req_ready); end
        step();
        checks++; if (w_en !== 4'b0 || rsp_valid !== 1'b0) begin errors++; $display("FAIL nc_c2 en %h rsp_valid %0b exp 0/0", w_en, rsp_valid); end
        step();
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL nc_c3_rsp_valid got %0b exp 1", rsp_valid); end
        checks++; if (w_rsp !== exp_rsp) begin errors++; $display("FAIL nc_rsp got %h exp %h", w_rsp, exp_rsp); end
        checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL nc_stall got %0d exp 0", stall_cnt); end
        handshake();
        checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin errors++; $display("FAIL nc_after_hs ready %0b valid %0b exp 1/0", req_ready, rsp_valid); end
    endtask

    task automatic test_all_bank1();
        logic [11:0] exp_rsp;
        exp_rsp = {lut(1'b1, 5'd1), lut(1'b1, 5'd2), lut(1'b1, 5'd3), lut(1'b1, 5'd4)};
        send(5'd1, 5'd2, 5'd3, 5'd4, 4'b1111);
        checks++; if (w_en !== 4'b0011) begin errors++; $display("FAIL b1_c1_en got %h exp 3", w_en); end
        checks++; if (w_addr !== {5'd0, 5'd0, 5'd1, 5'd2}) begin errors++; $display("FAIL b1_c1_addr got %h exp %h", w_addr, {5'd0, 5'd0, 5'd1, 5'd2}); end
        step();
        checks++; if (w_en !== 4'b0011) begin errors++; $display("FAIL b1_c2_en got %h exp 3", w_en); end
        checks++; if (w_addr !== {5'd0, 5'd0, 5'd3, 5'd4}) begin errors++; $display("FAIL b1_c2_addr got %h exp %h", w_addr, {5'd0, 5'd0, 5'd3, 5'd4}); end
        step();
        checks++; if (w_en !== 4'b0 || rsp_valid !== 1'b0) begin errors++; $display("FAIL b1_c3 en %h rsp_valid %0b exp 0/0", w_en, rsp_valid); end
        step();
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL b1_c4_rsp_valid got %0b exp 1", rsp_valid); end
        checks++; if (w_rsp !== exp_rsp) begin errors++; $display("FAIL b1_rsp got %h exp %h", w_rsp, exp_rsp); end
        checks++; if (stall_cnt !== 16'd1) begin errors++; $display("FAIL b1_stall got %0d exp 1", stall_cnt); end
        handshake();
    endtask

    task automatic test_three_bank0();
        logic [11:0] exp_rsp;
        exp_rsp = {lut(1'b0, 5'd5), lut(1'b0, 5'd9), lut(1'b1, 5'd17), lut(1'b0, 5'd30)};
        send(5'd5, 5'd9, 5'd17, 5'd30, 4'b0100);
        checks++; if (w_en !== 4'b1110) begin errors++; $display("FAIL t3_c1_en got %h exp e", w_en); end
        checks++; if (w_addr !== {5'd5, 5'd9, 5'd17, 5'd0}) begin errors++; $display("FAIL t3_c1_addr got %h exp %h", w_addr, {5'd5, 5'd9, 5'd17, 5'd0}); end
        step();
        checks++; if (w_en !== 4'b1000) begin errors++; $display("FAIL t3_c2_en got %h exp 8", w_en); end
        checks++; if (w_addr !== {5'd30, 5'd0, 5'd0, 5'd0}) begin errors++; $display("FAIL t3_c2_addr got %h exp %h", w_addr, {5'd30, 5'd0, 5'd0, 5'd0}); end
        step();
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL t3_c3_rsp_valid got %0b exp 0", rsp_valid); end
        step();
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL t3_c4_rsp_valid got %0b exp 1", rsp_valid); end
        checks++; if (w_rsp !== exp_rsp) begin errors++; $display("FAIL t3_rsp got %h exp %h", w_rsp, exp_rsp); end
        checks++; if (stall_cnt !== 16'd2) begin errors++; $display("FAIL t3_stall got %0d exp 2", stall_cnt); end
        handshake();
    endtask

    task automatic test_hold();
        logic [11:0] exp1, exp2;
        exp1 = {lut(1'b0, 5'd8), lut(1'b1, 5'd16), lut(1'b1, 5'd2), lut(1'b0, 5'd6)};
        exp2 = {lut(1'b1, 5'd10), lut(1'b0, 5'd11), lut(1'b0, 5'd20), lut(1'b1, 5'd21)};
        send(5'd8, 5'd16, 5'd2, 5'd6, 4'b0110);
        step();
        step();
        // cycle 3: result presented; offer a new batch while the consumer stalls
        page_addr_A = 5'd10; page_addr_B = 5'd11; page_addr_C = 5'd20; page_addr_D = 5'd21;
        bank_addr_A = 1'b1; bank_addr_B = 1'b0; bank_addr_C = 1'b0; bank_addr_D = 1'b1;
        req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checks++; if (rsp_valid !== 1'b1 || req_ready !== 1'b0) begin errors++; $display("FAIL hold_ctl[%0d] valid %0b ready %0b exp 1/0", i, rsp_valid, req_ready); end
            checks++; if (w_rsp !== exp1) begin errors++; $display("FAIL hold_rsp[%0d] got %h exp %h", i, w_rsp, exp1); end
            step();
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || w_en !== 4'b0) begin errors++; $display("FAIL hold_release ready %0b valid %0b en %h exp 1/0/0", req_ready, rsp_valid, w_en); end
        step();
        req_valid = 1'b0;
        checks++; if (w_en !== 4'b1111) begin errors++; $display("FAIL hold_b2_en got %h exp f", w_en); end
        checks++; if (w_addr !== {5'd11, 5'd20, 5'd10, 5'd21}) begin errors++; $display("FAIL hold_b2_addr got %h exp %h", w_addr, {5'd11, 5'd20, 5'd10, 5'd21}); end
        step();
        step();
        checks++; if (rsp_valid !== 1'b1 || w_rsp !== exp2) begin errors++; $display("FAIL hold_b2_rsp valid %0b got %h exp 1/%h", rsp_valid, w_rsp, exp2); end
        checks++; if (stall_cnt !== 16'd2) begin errors++; $display("FAIL hold_stall got %0d exp 2", stall_cnt); end
        handshake();
    endtask

    task automatic test_reset_mid();
        send(5'd1, 5'd2, 5'd3, 5'd4, 4'b0000);
        step();
        checks++; if (w_en !== 4'b1100 || w_addr !== {5'd3, 5'd4, 5'd0, 5'd0}) begin errors++; $display("FAIL rm_c2 en %h addr %h exp c/%h", w_en, w_addr, {5'd3, 5'd4, 5'd0, 5'd0}); end
        rst = 1'b1;
        #1;
        checks++; if (w_en !== 4'b0 || rsp_valid !== 1'b0 || w_addr !== 20'b0) begin errors++; $display("FAIL rm_async en %h valid %0b addr %h exp 0/0/0", w_en, rsp_valid, w_addr); end
        #2;
        rst = 1'b0;
        checks++; if (req_ready !== 1'b1 || stall_cnt !== 16'd0) begin errors++; $display("FAIL rm_release ready %0b stall %0d exp 1/0", req_ready, stall_cnt); end
        step();
        checks++; if (req_ready !== 1'b1 || w_en !== 4'b0) begin errors++; $display("FAIL rm_idle ready %0b en %h exp 1/0", req_ready, w_en); end
    endtask

    task automatic test_back_to_back();
        int hs, cyc;
        page_addr_A = 5'd0; page_addr_B = 5'd1; page_addr_C = 5'd2; page_addr_D = 5'd3;
        bank_addr_A = 1'b0; bank_addr_B = 1'b0; bank_addr_C = 1'b0; bank_addr_D = 1'b0;
        req_valid = 1'b1;
        rsp_ready = 1'b1;
        hs = 0;
        cyc = 0;
        while (cyc < 3000) begin
            if (req_ready) hs++;
            if (hs == 255) break;
            step();
            cyc++;
        end
        checks++; if (hs != 255 || cyc != 1270) begin errors++; $display("FAIL b2b_rate handshakes %0d cycle %0d exp 255/1270", hs, cyc); end
        step();
        checks++; if (stall_cnt !== STALL_MAX) begin errors++; $display("FAIL b2b_stall_max got %0d exp %0d", stall_cnt, STALL_MAX); end
        hs = 0;
        cyc = 0;
        while (hs < 6 && cyc < 200) begin
            if (req_ready) hs++;
            step();
            cyc++;
        end
        checks++; if (stall_cnt !== STALL_MAX || hs != 6) begin errors++; $display("FAIL b2b_saturate got %0d after %0d batches exp %0d", stall_cnt, hs, STALL_MAX); end
        req_valid = 1'b0;
        cyc = 0;
        while (!req_ready && cyc < 20) begin
            step();
            cyc++;
        end
        rsp_ready = 1'b0;
        checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain ready %0b valid %0b exp 1/0", req_ready, rsp_valid); end
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        page_addr_A = '0; page_addr_B = '0; page_addr_C = '0; page_addr_D = '0;
        bank_addr_A = 1'b0; bank_addr_B = 1'b0; bank_addr_C = 1'b0; bank_addr_D = 1'b0;
        #23;
        test_reset();
        rst = 1'b0;
        step();
        test_no_conflict();
        test_all_bank1();
        test_three_bank0();
        test_hold();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cn_lut_bank_sched.md
# cn_lut_bank_sched

Bank-conflict scheduler for the four-port decomposed check-node LUT. It accepts one batch of four (page, bank) lookups per handshake, as produced by the CN address-mapping stage. It issues the lookups to two interleaved dual-port LUT banks, serializing any bank that receives more than two requests, and returns the four LUT outputs together once all reads complete. It sits between the CN address decode and the bank memories, and provides the stall back-pressure to the CN message pipeline.

## Interface
- PAGE_W, 5, page address width (depth 2^PAGE_W per bank)
- DATA_W, 3, LUT output message width
- RD_LAT, 1, bank read latency in cycles (1..3)
- sys_clk  in  1  single clock, all logic rising-edge
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  batch request valid
- req_ready  out  1  scheduler can accept a batch
- page_addr_A/B/C/D  in  PAGE_W  page address per requester port
- bank_addr_A/B/C/D  in  1  bank select per requester port (0 = bank0, 1 = bank1)
- b0_en_0, b0_en_1, b1_en_0, b1_en_1  out  1  read enable, bank b, port p
- b0_addr_0, b0_addr_1, b1_addr_0, b1_addr_1  out  PAGE_W  read address, bank b, port p
- b0_dout_0, b0_dout_1, b1_dout_0, b1_dout_1  in  DATA_W  read data, valid RD_LAT cycles after the enable
- rsp_valid  out  1  result batch valid
- rsp_ready  in  1  consumer accepts the result
- rsp_A/B/C/D  out  DATA_W  LUT result per requester port
- stall_cnt  out  16  number of batches that needed two issue cycles; saturating

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: req_ready=1. On req_valid&&req_ready, latch all four page/bank values, set pending mask to 4'b1111, and go to ISSUE.
- ISSUE, each cycle, per bank:
  - Grant the two lowest-indexed pending requesters that target the bank (priority A>B>C>D).
  - The first grant goes to bank port 0 and the second to bank port 1.
  - Clear the granted bits from the pending mask.
- Tag pipeline: a delay line RD_LAT deep records, for each granted requester, its {bank, port}. When the tag emerges, the matching dout is captured into rsp_X.
- Leave ISSUE when the pending mask becomes 0. Go to WAIT until the tag pipeline is empty, then go to RESP.
- RESP: rsp_valid=1 and rsp_A..D held stable. On rsp_ready, go to IDLE.
- Bank enables and addresses depend only on registered state; there is no combinational path from req_* inputs.
- A bank port that is not enabled drives address 0.
- Issue cycles per batch = max over the two banks of ceil(n_b/2), so either 1 or 2.
  - If 2, stall_cnt increments once in the cycle the batch is accepted.
  - stall_cnt saturates at 16'hFFFF.
- Duplicate addresses are treated as independent requests. No merging.

## Timing
- Reset (async assert, synchronous release) values:
  - state=IDLE, req_ready=1, rsp_valid=0, all en=0, all addr=0.
  - rsp_A..D=0, pending mask=0, tag pipe empty, stall_cnt=0.
- Batch accepted at the edge ending cycle 0:
  - Enables are asserted in cycles 1..k, where k = issue cycles.
  - rsp_valid rises in cycle 1+k+RD_LAT.
  - With RD_LAT=1: no conflict gives rsp_valid in cycle 3; conflict gives cycle 4.
- req_ready=0 from cycle 1 until the cycle after the rsp handshake. Throughput is one batch per (k+RD_LAT+2) cycles when rsp_ready is held 1.
- rsp_valid held with rsp_ready=0: outputs frozen, no new acceptance.
- Reset mid-ISSUE/WAIT/RESP: in-flight batch discarded, and all outputs return to reset values immediately.
- req_valid asserted outside IDLE is ignored; the values are not latched.

## Test plan
- A,C to bank0 and B,D to bank1, pages 3/7/12/31, RD_LAT=1 -> the following, with stall_cnt=0:
  - cycle 1: b0_en_0/1 addr 3/12 and b1_en_0/1 addr 7/31.
  - rsp_valid in cycle 3 with each rsp_X = model LUT[bank][page].
- All four to bank1, pages 1,2,3,4 -> the following, with stall_cnt=1:
  - cycle 1: b1 ports carry 1/2; cycle 2: b1 ports carry 3/4.
  - b0 enables never asserted.
  - rsp_valid in cycle 4, results in A..D order.
- Three to bank0 (A,B,D) and C to bank1 -> the following:
  - cycle 1: b0 serves A,B and b1_en_0 serves C.
  - cycle 2: b0_en_0 serves D.
  - rsp_valid in cycle 4.
- Hold rsp_ready=0 for 5 cycles with req_valid=1 -> rsp_A..D stable, req_ready=0 throughout. Acceptance occurs one cycle after rsp_ready rises.
- Assert rst in cycle 2 of a conflicting batch -> all enables 0 and rsp_valid=0 in the same cycle. After release, req_ready=1 and stall_cnt=0.
- Run 70000 back-to-back all-bank0 batches -> stall_cnt saturates at 16'hFFFF and does not wrap.
